hazard_ctrl: RTL and testbench

- Pipeline hazard and stall/flush controller for the 5-stage RISC core.
- Watches the register operands of the instruction in IF/ID and compares them against the ID_EX outputs: destination register, MEM control and WB control.
- Drives the write-enables and bubble/flush controls back into PC, IF_ID and ID_EX.
- Handles load-use stalls, including multi-cycle data-memory latency, and taken-branch flushes resolved in MEM.

---
 rtl/core_pkg.sv | 20 ++
 rtl/hazard_cmp.sv | 28 ++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: pipeline control-bus bit indices, register address
// width and the hazard controller state type.
package core_pkg;

  localparam int unsigned MEM_READ    = 2;
  localparam int unsigned MEM_WRITE   = 1;
  localparam int unsigned MEM_BRANCH  = 0;
  localparam int unsigned WB_MEMTOREG = 1;
  localparam int unsigned WB_REGWRITE = 0;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned MEM_CTRL_W  = 3;
  localparam int unsigned WB_CTRL_W   = 2;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detector: flags an IF/ID operand that depends on a load
// still sitting in ID/EX. Purely combinational; x0 never matches.
module hazard_cmp
  import core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_use_rs1,
  input  logic                  ifid_use_rs2,
  input  logic [MEM_CTRL_W-1:0] idex_mem,
  input  logic [WB_CTRL_W-1:0]  idex_wb,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  output logic                  hz
);

  logic is_load;
  logic rs1_hit;
  logic rs2_hit;
  logic unused_ctrl;

  assign unused_ctrl = ^{idex_mem[MEM_WRITE], idex_mem[MEM_BRANCH], idex_wb[WB_MEMTOREG]};

  assign is_load = idex_mem[MEM_READ] & idex_wb[WB_REGWRITE] & (idex_rd != '0);
  assign rs1_hit = ifid_use_rs1 & (idex_rd == ifid_rs1);
  assign rs2_hit = ifid_use_rs2 & (idex_rd == ifid_rs2);
  assign hz      = is_load & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use stalls of LOAD_LAT cycles and
// taken-branch flushes. Optional perf counters behind HAZARD_PERF_EN.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned N        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_use_rs1,
  input  logic                  ifid_use_rs2,
  input  logic [MEM_CTRL_W-1:0] idex_mem,
  input  logic [WB_CTRL_W-1:0]  idex_wb,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  stalled
`ifdef HAZARD_PERF_EN
  ,
  output logic [N-1:0]          stall_cycles,
  output logic [N-1:0]          flush_events
`endif
);

  localparam logic [2:0] STALL_INIT = 3'(LOAD_LAT - 1);

  hz_state_e  state;
  logic [2:0] cnt;
  logic       hz;

  hazard_cmp u_cmp (
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .ifid_use_rs1 (ifid_use_rs1),
    .ifid_use_rs2 (ifid_use_rs2),
    .idex_mem     (idex_mem),
    .idex_wb      (idex_wb),
    .idex_rd      (idex_rd),
    .hz           (hz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else if (branch_taken) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (hz && (LOAD_LAT > 1)) begin
            state <= STALL;
            cnt   <= STALL_INIT;
          end
        end
        STALL: begin
          if (cnt == 3'd1) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs follow reset combinationally so the pipeline is held while rst_n is low.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stalled     = rst_n && (state == STALL);
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (state == STALL || hz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + N'(1);
      if (branch_taken && (flush_events != '1))
        flush_events <= flush_events + N'(1);
    end
  end
`else
  localparam int unsigned unused_perf_w = N;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share
// stimulus; perf counter checks apply when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_use_rs1, ifid_use_rs2;
  logic [2:0] idex_mem;
  logic [1:0] idex_wb;
  logic       branch_taken;

  logic a_pc, a_ifw, a_bub, a_iff, a_ief, a_emf, a_stl;
  logic b_pc, b_ifw, b_bub, b_iff, b_ief, b_emf, b_stl;
`ifdef HAZARD_PERF_EN
  logic [31:0] a_sc, a_fe, b_sc, b_fe;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .N(32)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_mem(idex_mem), .idex_wb(idex_wb), .idex_rd(idex_rd),
    .branch_taken(branch_taken),
    .pc_write(a_pc), .ifid_write(a_ifw), .idex_bubble(a_bub),
    .ifid_flush(a_iff), .idex_flush(a_ief), .exmem_flush(a_emf),
    .stalled(a_stl)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(a_sc), .flush_events(a_fe)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(3), .N(32)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_mem(idex_mem), .idex_wb(idex_wb), .idex_rd(idex_rd),
    .branch_taken(branch_taken),
    .pc_write(b_pc), .ifid_write(b_ifw), .idex_bubble(b_bub),
    .ifid_flush(b_iff), .idex_flush(b_ief), .exmem_flush(b_emf),
    .stalled(b_stl)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(b_sc), .flush_events(b_fe)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic br, input logic [2:0] mem, input logic [1:0] wb,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    @(negedge clk);
    branch_taken = br; idex_mem = mem; idex_wb = wb; idex_rd = rd;
    ifid_rs1 = rs1; ifid_use_rs1 = u1; ifid_rs2 = rs2; ifid_use_rs2 = u2;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 2'b00, 5'd0, 5'd1, 1'b0, 5'd2, 1'b0);
  endtask

  // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, stalled}
  function automatic logic [6:0] outs_a();
    return {a_pc, a_ifw, a_bub, a_iff, a_ief, a_emf, a_stl};
  endfunction
  function automatic logic [6:0] outs_b();
    return {b_pc, b_ifw, b_bub, b_iff, b_ief, b_emf, b_stl};
  endfunction

  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_HOLD  = 7'b0010000;
  localparam logic [6:0] O_STALL = 7'b0010001;
  localparam logic [6:0] O_FLUSH = 7'b1101110;
  localparam logic [6:0] O_RST   = 7'b0011110;

  initial begin
    rst_n = 1'b0;
    branch_taken = 1'b0; idex_mem = '0; idex_wb = '0; idex_rd = '0;
    ifid_rs1 = '0; ifid_rs2 = '0; ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();

    // Reset asserted mid-run while a branch is requested
    @(negedge clk);
    rst_n = 1'b0; branch_taken = 1'b1; #1;
    chk("rst_lat1", 32'(outs_a()), 32'(O_RST));
    chk("rst_lat3", 32'(outs_b()), 32'(O_RST));
    @(negedge clk);
    rst_n = 1'b1; branch_taken = 1'b0; #1;
    chk("rel_lat1", 32'(outs_a()), 32'(O_RUN));
    chk("rel_lat3", 32'(outs_b()), 32'(O_RUN));

    // Load-use on rs1; the load leaves ID_EX after the first cycle
    drive(1'b0, 3'b100, 2'b01, 5'd5, 5'd5, 1'b1, 5'd9, 1'b1);
    chk("lu_c1_lat1", 32'(outs_a()), 32'(O_HOLD));
    chk("lu_c1_lat3", 32'(outs_b()), 32'(O_HOLD));
    idle();
    chk("lu_c2_lat1", 32'(outs_a()), 32'(O_RUN));
    chk("lu_c2_lat3", 32'(outs_b()), 32'(O_STALL));
    idle();
    chk("lu_c3_lat1", 32'(outs_a()), 32'(O_RUN));
    chk("lu_c3_lat3", 32'(outs_b()), 32'(O_STALL));
    idle();
    chk("lu_c4_lat3", 32'(outs_b()), 32'(O_RUN));

    // STALL ignores detection inputs: a fresh match in cycle 2 must not extend the stall
    drive(1'b0, 3'b100, 2'b01, 5'd12, 5'd3, 1'b0, 5'd12, 1'b1);
    chk("rs2_c1_lat3", 32'(outs_b()), 32'(O_HOLD));
    drive(1'b0, 3'b100, 2'b01, 5'd12, 5'd3, 1'b0, 5'd12, 1'b1);
    chk("rs2_c2_lat1", 32'(outs_a()), 32'(O_HOLD));
    chk("rs2_c2_lat3", 32'(outs_b()), 32'(O_STALL));
    idle();
    chk("rs2_c3_lat3", 32'(outs_b()), 32'(O_STALL));
    idle();
    chk("rs2_c4_lat3", 32'(outs_b()), 32'(O_RUN));

    // No-hazard cases: x0 destination, non-load, unused operand, no regwrite
    drive(1'b0, 3'b100, 2'b01, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    chk("x0_lat3", 32'(outs_b()), 32'(O_RUN));
    drive(1'b0, 3'b010, 2'b01, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
    chk("noload_lat3", 32'(outs_b()), 32'(O_RUN));
    drive(1'b0, 3'b100, 2'b01, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
    chk("nouse_lat1", 32'(outs_a()), 32'(O_RUN));
    drive(1'b0, 3'b100, 2'b10, 5'd7, 5'd7, 1'b1, 5'd3, 1'b0);
    chk("noregw_lat3", 32'(outs_b()), 32'(O_RUN));

    // Hazard and taken branch together: branch wins, no stall follows
    drive(1'b1, 3'b100, 2'b01, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    chk("brhz_lat1", 32'(outs_a()), 32'(O_FLUSH));
    chk("brhz_lat3", 32'(outs_b()), 32'(O_FLUSH));
    idle();
    chk("brhz_nx_lat3", 32'(outs_b()), 32'(O_RUN));

    // Branch during STALL cycle 2 aborts the stall
    drive(1'b0, 3'b100, 2'b01, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    chk("abort_c1_lat3", 32'(outs_b()), 32'(O_HOLD));
    drive(1'b1, 3'b000, 2'b00, 5'd0, 5'd1, 1'b0, 5'd2, 1'b0);
    chk("abort_c2_pc", 32'(b_pc), 32'd1);
    chk("abort_c2_fl", 32'({b_iff, b_ief, b_emf, b_bub}), 32'b1110);
    idle();
    chk("abort_c3_lat3", 32'(outs_b()), 32'(O_RUN));

`ifdef HAZARD_PERF_EN
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("perf_rst_sc", b_sc, 32'd0);
    chk("perf_rst_fe", b_fe, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'b100, 2'b01, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    idle();
    idle();
    idle();
    drive(1'b1, 3'b000, 2'b00, 5'd0, 5'd1, 1'b0, 5'd2, 1'b0);
    idle();
    drive(1'b1, 3'b000, 2'b00, 5'd0, 5'd1, 1'b0, 5'd2, 1'b0);
    idle();
    chk("perf_sc_lat3", b_sc, 32'd3);
    chk("perf_fe_lat3", b_fe, 32'd2);
    chk("perf_sc_lat1", a_sc, 32'd1);
    chk("perf_fe_lat1", a_fe, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
